// File: rtl/uart_tx_arbiter_pkg.sv
// Shared FSM encoding, default widths and a watchdog default sized from clock/baud.
// Pure declarations: no latency or flow-control behaviour of its own.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  localparam int DEF_N_REQ      = 2;
  localparam int DEF_N_DATA     = 8;
  localparam int DEF_CLK_HZ     = 100_000_000;
  localparam int DEF_BAUD       = 9600;
  localparam int DEF_FRAME_BITS = 10;
  localparam int DEF_FRAME_CYC  = DEF_FRAME_BITS * (DEF_CLK_HZ / DEF_BAUD);
  // Round one 8N1 frame up to a power of two so a healthy frame never trips the watchdog.
  localparam int DEF_TIMEOUT_CYC = 1 << $clog2(DEF_FRAME_CYC);

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side valid/ready bus plus the uart_tx start/done hookup and status.
// slave = arbiter view; master = requesters/transmitter/monitor view.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int N_DATA = DEF_N_DATA
);
  localparam int GW = idx_width(N_REQ);

  logic [N_REQ-1:0]        i_req_valid;
  logic [N_REQ*N_DATA-1:0] i_req_data;
  logic [N_REQ-1:0]        o_req_ready;
  logic [N_DATA-1:0]       o_tx_data;
  logic                    o_tx_start;
  logic                    i_tx_done;
  logic [GW-1:0]           o_grant_id;
  logic                    o_busy;
  logic                    o_timeout;

  modport slave (
    input  i_req_valid, i_req_data, i_tx_done,
    output o_req_ready, o_tx_data, o_tx_start, o_grant_id, o_busy, o_timeout
  );

  modport master (
    output i_req_valid, i_req_data, i_tx_done,
    input  o_req_ready, o_tx_data, o_tx_start, o_grant_id, o_busy, o_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after i_ptr, wrapping, ending at i_ptr.
// Zero latency; no backpressure of its own.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int GW    = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [GW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!o_any && i_req[(int'(i_ptr) + i) % N_REQ]) begin
        o_any = 1'b1;
        o_gnt[(int'(i_ptr) + i) % N_REQ] = 1'b1;
        o_idx = GW'((int'(i_ptr) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx: accept in IDLE, 1-cycle start pulse, wait for done or watchdog.
// >=3 cycles + frame per byte; ready is offered only in IDLE, so requesters stall while a frame is in flight.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int N_DATA      = DEF_N_DATA,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int GW = idx_width(N_REQ);
  localparam int WW = idx_width(TIMEOUT_CYC);
  localparam logic [WW-1:0] WDOG_TERM = WW'(TIMEOUT_CYC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_ptr;
  logic [GW-1:0]     r_grant_id;
  logic [N_DATA-1:0] r_tx_data;
  logic [WW-1:0]     r_wdog;
  logic              r_timeout;

  logic [N_REQ-1:0]  w_gnt;
  logic [GW-1:0]     w_idx;
  logic              w_any;
  logic [N_REQ-1:0]  w_req_ready;
  logic              w_accept;
  logic              w_wdog_term;
  logic [N_DATA-1:0] w_sel_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr_arbiter (
    .i_req (bus.i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_accept    = (r_state == ST_IDLE) && w_any;
  assign w_wdog_term = (r_wdog == WDOG_TERM);
  assign w_sel_data  = bus.i_req_data[int'(w_idx)*N_DATA +: N_DATA];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_req_ready = w_gnt;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.i_tx_done || w_wdog_term) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr      <= GW'(N_REQ - 1);
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_wdog     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      // A done in the terminal cycle takes priority over the abort.
      r_timeout <= (r_state == ST_WAIT_DONE) && !bus.i_tx_done && w_wdog_term;
      if (w_accept) begin
        r_tx_data  <= w_sel_data;
        r_grant_id <= w_idx;
        r_ptr      <= w_idx;
      end
      if (r_state == ST_START) begin
        r_wdog <= '0;
      end else if (r_state == ST_WAIT_DONE) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  assign bus.o_req_ready = w_req_ready;
  assign bus.o_tx_data   = r_tx_data;
  assign bus.o_tx_start  = (r_state == ST_START);
  assign bus.o_grant_id  = r_grant_id;
  assign bus.o_busy      = (r_state != ST_IDLE);
  assign bus.o_timeout   = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (N_REQ=2, TIMEOUT_CYC=16): vector table, corner sequences, random run vs a cycle-timeline model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N_REQ  = 2;
  localparam int N_DATA = 8;
  localparam int TO     = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .N_DATA(N_DATA)) bus ();

  uart_tx_arbiter #(
    .N_REQ       (N_REQ),
    .N_DATA      (N_DATA),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1, input logic done);
    bus.i_req_valid = v;
    bus.i_req_data  = {d1, d0};
    bus.i_tx_done   = done;
  endtask

  task automatic do_reset();
    drive(2'b00, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int pick(input int p, input logic [1:0] v);
    for (int i = 1; i <= N_REQ; i++) begin
      if (v[(p + i) % N_REQ]) return (p + i) % N_REQ;
    end
    return -1;
  endfunction

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_ready;
    logic       exp_gid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  int bad, to_cnt, to_at, k, exp_k;
  logic [7:0] seq_exp [4];

  int m_idle_from, m_start, m_to, m_done, m_win_lo, m_win_hi, m_ptr, m_gid, m_win, m_delay;
  logic [7:0] m_data, r_d0, r_d1;
  logic [1:0] r_v, m_ready;
  logic r_done;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(2'b00, 8'h00, 8'h00, 1'b0);

    // ---------------- reset state + single request
    do_reset();
    #1;
    chk("rst_outputs", {bus.o_busy, bus.o_tx_start, bus.o_timeout, bus.o_grant_id, bus.o_tx_data}, 0);
    chk("rst_ready", bus.o_req_ready, 2'b00);
    @(negedge clk); drive(2'b01, 8'h41, 8'h00, 1'b0);
    #1 chk("single_ready", bus.o_req_ready, 2'b01);
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);
    #1;
    chk("single_ready_drop", bus.o_req_ready, 2'b00);
    chk("single_start", bus.o_tx_start, 1'b1);
    chk("single_data_gid", {bus.o_grant_id, bus.o_tx_data}, {1'b0, 8'h41});
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk); #1;
      if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) bad++;
    end
    chk("single_wait", bad, 0);
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b1);
    #1 chk("single_busy_at_done", bus.o_busy, 1'b1);
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);
    #1 chk("single_busy_fall", {bus.o_busy, bus.o_timeout}, 2'b00);

    // ---------------- table-driven arbitration vectors
    vecs[0] = '{2'b01, 8'h41, 8'h00, 2'b01, 1'b0, 8'h41};
    vecs[1] = '{2'b11, 8'h11, 8'h22, 2'b10, 1'b1, 8'h22};
    vecs[2] = '{2'b11, 8'h33, 8'h44, 2'b01, 1'b0, 8'h33};
    vecs[3] = '{2'b01, 8'h55, 8'h66, 2'b01, 1'b0, 8'h55};
    vecs[4] = '{2'b10, 8'h77, 8'h88, 2'b10, 1'b1, 8'h88};
    vecs[5] = '{2'b10, 8'h99, 8'hAA, 2'b10, 1'b1, 8'hAA};
    vecs[6] = '{2'b00, 8'hDE, 8'hAD, 2'b00, 1'b1, 8'hAA};
    vecs[7] = '{2'b11, 8'hBB, 8'hCC, 2'b01, 1'b0, 8'hBB};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(vecs[i].valid, vecs[i].d0, vecs[i].d1, 1'b0);
      #1 chk($sformatf("vec%0d_ready", i), bus.o_req_ready, vecs[i].exp_ready);
      @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);
      #1;
      chk($sformatf("vec%0d_gid_data", i), {bus.o_grant_id, bus.o_tx_data}, {vecs[i].exp_gid, vecs[i].exp_data});
      chk($sformatf("vec%0d_start", i), bus.o_tx_start, (vecs[i].exp_ready != 2'b00));
      if (vecs[i].exp_ready != 2'b00) begin
        @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b1);
        @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);
        #1 chk($sformatf("vec%0d_idle", i), bus.o_busy, 1'b0);
      end
    end

    // ---------------- contention: both valid, done 5 cycles after each start
    seq_exp[0] = 8'h11; seq_exp[1] = 8'h22; seq_exp[2] = 8'h11; seq_exp[3] = 8'h22;
    do_reset();
    drive(2'b11, 8'h11, 8'h22, 1'b0);
    for (int t = 0; t < 4; t++) begin
      exp_k = (t == 0) ? 1 : 2;
      k = 0;
      for (int j = 1; j <= 8; j++) begin
        @(negedge clk); drive(2'b11, 8'h11, 8'h22, 1'b0);
        #1;
        if (bus.o_tx_start === 1'b1) begin
          k = j;
          break;
        end
      end
      chk($sformatf("cont%0d_start_delay", t), k, exp_k);
      chk($sformatf("cont%0d_data", t), bus.o_tx_data, seq_exp[t]);
      repeat (4) @(negedge clk);
      @(negedge clk); drive(2'b11, 8'h11, 8'h22, 1'b1);
    end
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);

    // ---------------- timeout, then a late done that must be ignored
    do_reset();
    @(negedge clk); drive(2'b10, 8'h00, 8'h5A, 1'b0);
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);
    #1 chk("to_grant", {bus.o_tx_start, bus.o_grant_id, bus.o_tx_data}, {1'b1, 1'b1, 8'h5A});
    bad = 0; to_cnt = 0; to_at = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk); drive(2'b00, 8'h00, 8'h00, (i == 19));
      #1;
      if (bus.o_timeout === 1'b1) begin
        to_cnt++;
        to_at = i;
      end
      if (i <= 16 && bus.o_busy !== 1'b1) bad++;
      if (i >= 17 && (bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0 || bus.o_req_ready !== 2'b00)) bad++;
    end
    chk("to_pulse_count", to_cnt, 1);
    chk("to_pulse_cycle", to_at, 17);
    chk("to_busy_and_late_done", bad, 0);

    // ---------------- done coincident with the terminal watchdog count
    do_reset();
    @(negedge clk); drive(2'b01, 8'h3C, 8'h00, 1'b0);
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);
    to_cnt = 0; bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); drive(2'b00, 8'h00, 8'h00, (i == 16));
      #1;
      if (bus.o_timeout === 1'b1) to_cnt++;
      if (i == 16 && bus.o_busy !== 1'b1) bad++;
      if (i == 17 && bus.o_busy !== 1'b0) bad++;
    end
    chk("term_no_timeout", to_cnt, 0);
    chk("term_busy_edges", bad, 0);

    // ---------------- async reset while waiting for done
    do_reset();
    @(negedge clk); drive(2'b01, 8'h77, 8'h00, 1'b0);
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("arst_outputs", {bus.o_busy, bus.o_tx_start, bus.o_timeout, bus.o_grant_id, bus.o_tx_data}, 0);
    @(negedge clk); rst = 1'b0; drive(2'b11, 8'h01, 8'h02, 1'b0);
    #1 chk("arst_rr_first", bus.o_req_ready, 2'b01);
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b1);
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);

    // ---------------- valid withdrawn while busy
    do_reset();
    @(negedge clk); drive(2'b01, 8'h12, 8'h00, 1'b0);
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);
    @(negedge clk); drive(2'b10, 8'h00, 8'h99, 1'b0);
    #1 chk("wd_ready_busy", bus.o_req_ready, 2'b00);
    @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b1);
    bad = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); drive(2'b00, 8'h00, 8'h00, 1'b0);
      #1;
      if (bus.o_req_ready !== 2'b00 || bus.o_tx_start !== 1'b0 || bus.o_grant_id !== 1'b0 || bus.o_busy !== 1'b0) bad++;
    end
    chk("wd_no_grant", bad, 0);

    // ---------------- randomized run against a cycle-timeline model
    do_reset();
    m_idle_from = 0; m_start = -1; m_to = -1; m_done = -1;
    m_win_lo = -1; m_win_hi = -1; m_ptr = N_REQ - 1; m_gid = 0; m_data = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r_v  = 2'($urandom_range(0, 3));
      r_d0 = 8'($urandom);
      r_d1 = 8'($urandom);
      r_done = (c == m_done) ||
               (($urandom_range(0, 7) == 0) && !(c >= m_win_lo && c <= m_win_hi));
      drive(r_v, r_d0, r_d1, r_done);
      #1;
      m_ready = 2'b00;
      m_win = -1;
      if (c >= m_idle_from && r_v != 2'b00) begin
        m_win = pick(m_ptr, r_v);
        m_ready[m_win] = 1'b1;
      end
      chk($sformatf("rand_c%0d", c),
          {18'd0, bus.o_req_ready, bus.o_busy, bus.o_tx_start, bus.o_timeout, bus.o_grant_id, bus.o_tx_data},
          {18'd0, m_ready, (c < m_idle_from), (c == m_start), (c == m_to), 1'(m_gid), m_data});
      if (m_win >= 0) begin
        m_ptr    = m_win;
        m_gid    = m_win;
        m_data   = (m_win == 1) ? r_d1 : r_d0;
        m_start  = c + 1;
        m_win_lo = c + 2;
        m_delay  = $urandom_range(0, 19);
        if (m_delay <= TO - 1) begin
          m_done      = m_win_lo + m_delay;
          m_idle_from = m_done + 1;
          m_win_hi    = m_done;
          m_to        = -1;
        end else begin
          m_idle_from = m_win_lo + TO;
          m_to        = m_idle_from;
          m_win_hi    = m_idle_from - 1;
          m_done      = m_idle_from + $urandom_range(0, 1);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
